gate_tester: RTL

Self-checking stimulus/response block for the three-output logic gate unit (y[2]=AND, y[1]=OR, y[0]=NOT a). It drives the gate unit's a/b inputs through all four input combinations and receives its y outputs. Each vector is held for a programmable number of clocks, then y is compared against locally computed expected values. Mismatches are counted and flagged per vector, replacing manual waveform inspection with an on-chip pass/fail result.

---
 rtl/gate_tester.sv | 107 ++++++++++
 1 files changed

// File: rtl/gate_tester.sv
// gate_tester: drives the AND/OR/NOT gate unit through all four {a,b} vectors and checks y on chip.
// Optional feature macro: GATE_TESTER_STOP_ON_FAIL_EN (end the run at the first mismatching vector).
module gate_tester #(
  parameter int HOLD_CYCLES = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] y,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

`ifdef GATE_TESTER_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    DONE
  } state_t;

  state_t     state;
  logic [1:0] vec;
  logic [7:0] hold;
  logic [2:0] expected;
  logic       mismatch;
  logic       sample;
  logic [2:0] err_next;
  logic [3:0] fail_next;

  // vec is reset to 0 and frozen in DONE, so a/b follow it in every state
  assign a = vec[1];
  assign b = vec[0];

  always_comb begin
    expected  = {vec[1] & vec[0], vec[1] | vec[0], ~vec[1]};
    mismatch  = (y != expected);
    sample    = (state == DRIVE) && (hold == HOLD_LAST);
    err_next  = err_count;
    fail_next = fail_vec;
    if (sample && mismatch) begin
      if (err_count != 3'd4) begin
        err_next = err_count + 3'd1;
      end
      fail_next[vec] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      vec       <= 2'd0;
      hold      <= 8'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= 3'd0;
      fail_vec  <= 4'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= DRIVE;
            vec       <= 2'd0;
            hold      <= 8'd0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= 3'd0;
            fail_vec  <= 4'd0;
          end
        end
        DRIVE: begin
          err_count <= err_next;
          fail_vec  <= fail_next;
          if (sample) begin
            // pass uses the post-compare count so it is valid the cycle done rises
            if (vec == 2'd3 || (STOP_ON_FAIL && mismatch)) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_next == 3'd0);
            end else begin
              vec  <= vec + 2'd1;
              hold <= 8'd0;
            end
          end else begin
            hold <= hold + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
